svc_rv_bram_arb: RTL and testbench

SVC_RV_BRAM_ARB -- requirements
Module: svc_rv_bram_arb

---
 rtl/svc_rv_bram_arb_pkg.sv | 16 +
 rtl/svc_arb_rr2.sv | 42 ++++
 rtl/svc_rv_bram_arb.sv | 83 ++++++++
 tb/tb_svc_rv_bram_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svc_rv_bram_arb_pkg.sv
// Shared constants and types for the two-port BRAM arbiter.
// The owner tag records which requester a pending read belongs to.
package svc_rv_bram_arb_pkg;

   localparam int N_REQ = 2;

   typedef enum logic [0:0] {
      OWNER_CPU = 1'b0,
      OWNER_DBG = 1'b1
   } owner_t;

   function automatic logic [N_REQ-1:0] owner_onehot(input owner_t owner);
      return (owner == OWNER_DBG) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/svc_arb_rr2.sv
// Two-requester arbiter: same-cycle combinational grant, with a 1-bit
// last-grant pointer for round-robin tie breaking (RR=1) or fixed priority (RR=0).
module svc_arb_rr2
   import svc_rv_bram_arb_pkg::*;
#(
   parameter int RR = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output owner_t           owner
);

   owner_t           last;
   logic [N_REQ-1:0] gnt_raw;

   always_comb begin
      // NOTE: default assignment first so no path leaves gnt_raw unassigned (no latch).
      gnt_raw = '0;
      case (req)
         2'b01:   gnt_raw = 2'b01;
         2'b10:   gnt_raw = 2'b10;
         2'b11:   gnt_raw = (RR != 0 && last == OWNER_CPU) ? 2'b10 : 2'b01;
         default: gnt_raw = '0;
      endcase
   end

   // Grants are suppressed during reset so a read in the reset cycle is squashed.
   assign gnt   = rst ? '0 : gnt_raw;
   assign owner = gnt[1] ? OWNER_DBG : OWNER_CPU;

   // NOTE: non-blocking assignments for all sequential state, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= OWNER_DBG;
      end else if (|gnt) begin
         last <= owner;
      end
   end

endmodule

// File: rtl/svc_rv_bram_arb.sv
// Arbitrates a CPU data port and a debug/loader port onto one single-port BRAM,
// routes read data back via a registered owner tag, and counts per-requester stalls.
module svc_rv_bram_arb
   import svc_rv_bram_arb_pkg::*;
#(
   parameter int AW = 10,
   parameter int DW = 32,
   parameter int RR = 1,
   parameter int CW = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              m_req,
   input  logic [N_REQ-1:0]              m_we,
   input  logic [N_REQ-1:0][AW-1:0]      m_addr,
   input  logic [N_REQ-1:0][DW-1:0]      m_wdata,
   input  logic [N_REQ-1:0][DW/8-1:0]    m_wstrb,
   output logic [N_REQ-1:0]              m_gnt,
   output logic [N_REQ-1:0]              m_rvalid,
   output logic [DW-1:0]                 m_rdata,
   output logic                          bram_en,
   output logic [DW/8-1:0]               bram_we,
   output logic [AW-1:0]                 bram_addr,
   output logic [DW-1:0]                 bram_wdata,
   input  logic [DW-1:0]                 bram_rdata,
   output logic [CW-1:0]                 stall_cnt0,
   output logic [CW-1:0]                 stall_cnt1
);

   owner_t                  gnt_owner;
   owner_t                  rd_owner;
   logic                    sel;
   logic                    rd_pend;
   logic [N_REQ-1:0][CW-1:0] stall_q;

   svc_arb_rr2 #(.RR(RR)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (m_req),
      .gnt   (m_gnt),
      .owner (gnt_owner)
   );

   assign sel = gnt_owner;

   // Payload is zeroed when idle so the BRAM side is quiet outside grant cycles.
   assign bram_en    = |m_gnt;
   assign bram_addr  = bram_en ? m_addr[sel]  : '0;
   assign bram_wdata = bram_en ? m_wdata[sel] : '0;
   assign bram_we    = (bram_en && m_we[sel]) ? m_wstrb[sel] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend  <= 1'b0;
         rd_owner <= OWNER_CPU;
      end else begin
         rd_pend <= bram_en && !m_we[sel];
         if (bram_en) begin
            rd_owner <= gnt_owner;
         end
      end
   end

   assign m_rvalid = rd_pend ? owner_onehot(rd_owner) : '0;
   assign m_rdata  = rd_pend ? bram_rdata : '0;

   // Saturating wait counters: a requester stalls when it asks and is not granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (m_req[i] && !m_gnt[i] && stall_q[i] != '1) begin
               stall_q[i] <= stall_q[i] + 1'b1;
            end
         end
      end
   end

   assign stall_cnt0 = stall_q[0];
   assign stall_cnt1 = stall_q[1];

endmodule

// File: tb/tb_svc_rv_bram_arb.sv
// Bench for svc_rv_bram_arb: a round-robin (CW=16) and a fixed-priority (CW=4)
// instance share stimulus; each has its own BRAM model and reference model.
module tb_svc_rv_bram_arb;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]       req, we;
   logic [1:0][9:0]  addr;
   logic [1:0][31:0] wdata;
   logic [1:0][3:0]  wstrb;

   logic [1:0]  gnt_o    [2];
   logic [1:0]  rv_o     [2];
   logic [31:0] rdata_o  [2];
   logic        en_o     [2];
   logic [3:0]  bwe_o    [2];
   logic [9:0]  baddr_o  [2];
   logic [31:0] bwdata_o [2];
   logic [31:0] brdata   [2];
   logic [15:0] sc0_o    [2];
   logic [15:0] sc1_o    [2];
   logic [3:0]  sc_fp0, sc_fp1;

   logic [31:0] bmem0 [1024];
   logic [31:0] bmem1 [1024];

   int errors = 0;
   int checks = 0;

   // Reference model state, index 0 = round-robin instance, 1 = fixed priority.
   int          last_m [2];
   int          cnt_m  [2][2];
   int          cmax   [2] = '{65535, 15};
   logic [1:0]  rv_m   [2];
   logic [31:0] rd_m   [2];
   logic [31:0] ref_mem [2][1024];

   always #5 clk = ~clk;

   svc_rv_bram_arb #(.AW(10), .DW(32), .RR(1), .CW(16)) dut_rr (
      .clk(clk), .rst(rst), .m_req(req), .m_we(we), .m_addr(addr), .m_wdata(wdata),
      .m_wstrb(wstrb), .m_gnt(gnt_o[0]), .m_rvalid(rv_o[0]), .m_rdata(rdata_o[0]),
      .bram_en(en_o[0]), .bram_we(bwe_o[0]), .bram_addr(baddr_o[0]),
      .bram_wdata(bwdata_o[0]), .bram_rdata(brdata[0]),
      .stall_cnt0(sc0_o[0]), .stall_cnt1(sc1_o[0])
   );

   svc_rv_bram_arb #(.AW(10), .DW(32), .RR(0), .CW(4)) dut_fp (
      .clk(clk), .rst(rst), .m_req(req), .m_we(we), .m_addr(addr), .m_wdata(wdata),
      .m_wstrb(wstrb), .m_gnt(gnt_o[1]), .m_rvalid(rv_o[1]), .m_rdata(rdata_o[1]),
      .bram_en(en_o[1]), .bram_we(bwe_o[1]), .bram_addr(baddr_o[1]),
      .bram_wdata(bwdata_o[1]), .bram_rdata(brdata[1]),
      .stall_cnt0(sc_fp0), .stall_cnt1(sc_fp1)
   );

   assign sc0_o[1] = {12'd0, sc_fp0};
   assign sc1_o[1] = {12'd0, sc_fp1};

   // Byte-enabled BRAMs with one-cycle read latency.
   always @(posedge clk) begin
      if (en_o[0]) begin
         for (int b = 0; b < 4; b++)
            if (bwe_o[0][b]) bmem0[baddr_o[0]][8*b +: 8] <= bwdata_o[0][8*b +: 8];
         brdata[0] <= bmem0[baddr_o[0]];
      end
   end

   always @(posedge clk) begin
      if (en_o[1]) begin
         for (int b = 0; b < 4; b++)
            if (bwe_o[1][b]) bmem1[baddr_o[1]][8*b +: 8] <= bwdata_o[1][8*b +: 8];
         brdata[1] <= bmem1[baddr_o[1]];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] model_gnt(input logic [1:0] r, input int last, input bit rr);
      if (r == 2'b11) return (rr && last == 0) ? 2'b10 : 2'b01;
      return r;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         last_m[c] = 1;
         cnt_m[c]  = '{0, 0};
         rv_m[c]   = 2'b00;
      end
   endtask

   task automatic model_update(input int c, input logic [1:0] g);
      int sel;
      rv_m[c] = 2'b00;
      for (int i = 0; i < 2; i++)
         if (req[i] && !g[i] && cnt_m[c][i] < cmax[c]) cnt_m[c][i]++;
      if (g != 2'b00) begin
         sel = g[1] ? 1 : 0;
         last_m[c] = sel;
         if (we[sel]) begin
            for (int b = 0; b < 4; b++)
               if (wstrb[sel][b]) ref_mem[c][addr[sel]][8*b +: 8] = wdata[sel][8*b +: 8];
         end else begin
            rv_m[c][sel] = 1'b1;
            rd_m[c] = ref_mem[c][addr[sel]];
         end
      end
   endtask

   // Checks combinational grant and BRAM request side mid-cycle.
   task automatic tick_comb();
      logic [1:0] eg;
      int sel;
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
         eg = model_gnt(req, last_m[c], c == 0);
         sel = eg[1] ? 1 : 0;
         check("gnt", gnt_o[c], eg);
         check("bram_en", en_o[c], eg != 2'b00);
         if (eg != 2'b00) begin
            check("bram_addr", baddr_o[c], addr[sel]);
            check("bram_wdata", bwdata_o[c], wdata[sel]);
            check("bram_we", bwe_o[c], we[sel] ? wstrb[sel] : 4'h0);
         end else begin
            check("bram_we_idle", bwe_o[c], 4'h0);
         end
      end
   endtask

   // Advances one edge, updates the model, then checks registered outputs.
   task automatic tick_edge();
      logic [1:0] eg [2];
      for (int c = 0; c < 2; c++) eg[c] = model_gnt(req, last_m[c], c == 0);
      @(posedge clk);
      for (int c = 0; c < 2; c++) model_update(c, eg[c]);
      #1;
      for (int c = 0; c < 2; c++) begin
         check("rvalid", rv_o[c], rv_m[c]);
         if (rv_m[c] != 2'b00) check("rdata", rdata_o[c], rd_m[c]);
         check("stall_cnt0", sc0_o[c], 64'(cnt_m[c][0]));
         check("stall_cnt1", sc1_o[c], 64'(cnt_m[c][1]));
      end
   endtask

   typedef struct {
      logic [1:0]  req, we;
      logic [9:0]  a0, a1;
      logic [31:0] wd1;
      logic [3:0]  ws1;
      logic [1:0]  g_rr, g_fp, rv_rr, rv_fp;
      logic [31:0] rd_rr, rd_fp;
   } vec_t;

   vec_t tbl [10];
   int   run [2];
   int   max_run;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         bmem0[i] = 32'h0; bmem1[i] = 32'h0;
         ref_mem[0][i] = 32'h0; ref_mem[1][i] = 32'h0;
      end
      bmem0[5] = 32'hDEAD_BEEF; bmem1[5] = 32'hDEAD_BEEF;
      bmem0[1] = 32'h1111_1111; bmem1[1] = 32'h1111_1111;
      bmem0[2] = 32'h2222_2222; bmem1[2] = 32'h2222_2222;
      for (int c = 0; c < 2; c++) begin
         ref_mem[c][5] = 32'hDEAD_BEEF;
         ref_mem[c][1] = 32'h1111_1111;
         ref_mem[c][2] = 32'h2222_2222;
      end

      tbl[0] = '{2'b11, 2'b00, 10'd1, 10'd2, 32'h0, 4'h0, 2'b01, 2'b01, 2'b01, 2'b01, 32'h1111_1111, 32'h1111_1111};
      tbl[1] = '{2'b11, 2'b00, 10'd1, 10'd2, 32'h0, 4'h0, 2'b10, 2'b01, 2'b10, 2'b01, 32'h2222_2222, 32'h1111_1111};
      tbl[2] = tbl[0];
      tbl[3] = tbl[1];
      tbl[4] = tbl[0];
      tbl[5] = tbl[1];
      tbl[6] = '{2'b01, 2'b00, 10'd5, 10'd0, 32'h0, 4'h0, 2'b01, 2'b01, 2'b01, 2'b01, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      tbl[7] = '{2'b10, 2'b10, 10'd0, 10'd3, 32'h1234_5678, 4'h3, 2'b10, 2'b10, 2'b00, 2'b00, 32'h0, 32'h0};
      tbl[8] = '{2'b01, 2'b00, 10'd3, 10'd0, 32'h0, 4'h0, 2'b01, 2'b01, 2'b01, 2'b01, 32'h0000_5678, 32'h0000_5678};
      tbl[9] = '{2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0};

      rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; wstrb = '0;
      model_reset();
      #3;
      for (int c = 0; c < 2; c++) begin
         check("rst_gnt", gnt_o[c], 2'b00);
         check("rst_rvalid", rv_o[c], 2'b00);
         check("rst_stall0", sc0_o[c], 16'd0);
         check("rst_stall1", sc1_o[c], 16'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed table: tie sequence, single read, strobed write then read-back.
      for (int k = 0; k < 10; k++) begin
         req = tbl[k].req; we = tbl[k].we;
         addr[0] = tbl[k].a0; addr[1] = tbl[k].a1;
         wdata[0] = 32'h0; wdata[1] = tbl[k].wd1;
         wstrb[0] = 4'h0;  wstrb[1] = tbl[k].ws1;
         tick_comb();
         check("tbl_gnt_rr", gnt_o[0], tbl[k].g_rr);
         check("tbl_gnt_fp", gnt_o[1], tbl[k].g_fp);
         tick_edge();
         check("tbl_rv_rr", rv_o[0], tbl[k].rv_rr);
         check("tbl_rv_fp", rv_o[1], tbl[k].rv_fp);
         if (tbl[k].rv_rr != 2'b00) check("tbl_rdata_rr", rdata_o[0], tbl[k].rd_rr);
         if (tbl[k].rv_fp != 2'b00) check("tbl_rdata_fp", rdata_o[1], tbl[k].rd_fp);
         if (k == 5) begin
            check("tie_stall0_rr", sc0_o[0], 16'd3);
            check("tie_stall1_rr", sc1_o[0], 16'd3);
            check("tie_stall0_fp", sc0_o[1], 16'd0);
            check("tie_stall1_fp", sc1_o[1], 16'd6);
         end
      end

      // Random traffic against the reference model.
      run = '{0, 0};
      max_run = 0;
      for (int n = 0; n < 300; n++) begin
         req = 2'($urandom_range(0, 3));
         we  = 2'($urandom_range(0, 3));
         for (int i = 0; i < 2; i++) begin
            addr[i]  = 10'($urandom_range(0, 15));
            wdata[i] = $urandom;
            wstrb[i] = 4'($urandom_range(0, 15));
         end
         tick_comb();
         for (int i = 0; i < 2; i++) begin
            if (req[i] && !gnt_o[0][i]) run[i]++;
            else run[i] = 0;
            if (run[i] > max_run) max_run = run[i];
         end
         tick_edge();
      end
      check("rr_max_wait_gt1", max_run > 1, 1'b0);

      // Starvation of requester 1 under fixed priority saturates the 4-bit counter.
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      req = 2'b11; we = 2'b00; addr[0] = 10'd1; addr[1] = 10'd2;
      for (int n = 0; n < 20; n++) begin
         tick_comb();
         tick_edge();
      end
      check("starve_stall1_fp", sc1_o[1], 16'd15);
      check("starve_stall0_fp", sc0_o[1], 16'd0);
      check("starve_stall1_rr", sc1_o[0], 16'd10);

      // Reset asserted during a granted read squashes its rvalid.
      req = 2'b01; we = 2'b00; addr[0] = 10'd5;
      tick_comb();
      #2 rst = 1'b1;
      #1;
      for (int c = 0; c < 2; c++) begin
         check("inrst_gnt", gnt_o[c], 2'b00);
         check("inrst_en", en_o[c], 1'b0);
         check("inrst_we", bwe_o[c], 4'h0);
         check("inrst_addr", baddr_o[c], 10'd0);
         check("inrst_wdata", bwdata_o[c], 32'h0);
         check("inrst_rvalid", rv_o[c], 2'b00);
         check("inrst_rdata", rdata_o[c], 32'h0);
         check("inrst_stall0", sc0_o[c], 16'd0);
         check("inrst_stall1", sc1_o[c], 16'd0);
      end
      model_reset();
      @(posedge clk); #1;
      for (int c = 0; c < 2; c++) check("squash_rvalid", rv_o[c], 2'b00);
      req = 2'b11; addr[1] = 10'd2;
      rst = 1'b0;
      tick_comb();
      check("post_rst_tie_rr", gnt_o[0], 2'b01);
      check("post_rst_tie_fp", gnt_o[1], 2'b01);
      tick_edge();
      tick_comb();
      check("post_rst_second_rr", gnt_o[0], 2'b10);
      tick_edge();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
